// File: rtl/tdes_pkg.sv
// tdes_pkg: shared constants and types for the Triple-DES sequencer.
// Holds state encoding, pass indices and key/direction selection.
package tdes_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [1:0] PASS_0 = 2'd0;
  localparam logic [1:0] PASS_1 = 2'd1;
  localparam logic [1:0] PASS_2 = 2'd2;

  localparam logic [7:0] TIMEOUT_DEF = 8'd127;

  typedef struct packed {
    logic        mode;
    logic        decrypt;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
  } req_t;

  typedef struct packed {
    logic [63:0] key;
    logic        decrypt;
  } pass_cfg_t;

  // EDE order: enc K1/K2/K3, dec K3/K2/K1; middle pass flips direction.
  function automatic pass_cfg_t sel_pass(
    input logic [1:0] pass,
    input req_t       r
  );
    pass_cfg_t c;
    c.key     = r.key1;
    c.decrypt = r.decrypt;
    if (r.mode) begin
      if (pass == PASS_1) begin
        c.key     = r.key2;
        c.decrypt = !r.decrypt;
      end else if ((pass == PASS_0) && r.decrypt) begin
        c.key = r.key3;
      end else if ((pass == PASS_2) && !r.decrypt) begin
        c.key = r.key3;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/tdes_if.sv
// tdes_if: request/response bundle between a host and tdes_seq.
// master drives requests; slave (the sequencer) drives responses.
interface tdes_if;
  logic        i_valid;
  logic        i_mode;
  logic        i_decrypt;
  logic [63:0] i_data;
  logic [63:0] i_key1;
  logic [63:0] i_key2;
  logic [63:0] i_key3;
  logic        o_ready;
  logic        o_valid;
  logic        o_error;
  logic [63:0] o_data;
  logic [1:0]  o_pass;

  modport master (
    output i_valid, i_mode, i_decrypt,
    output i_data, i_key1, i_key2, i_key3,
    input  o_ready, o_valid, o_error,
    input  o_data, o_pass
  );

  modport slave (
    input  i_valid, i_mode, i_decrypt,
    input  i_data, i_key1, i_key2, i_key3,
    output o_ready, o_valid, o_error,
    output o_data, o_pass
  );
endinterface

// File: rtl/tdes_timer.sv
// tdes_timer: per-pass watchdog for engine completion.
// expired flags the WAIT cycle on which the count reaches TIMEOUT.
module tdes_timer
  import tdes_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = enable &&
    (({1'b0, cnt} + 9'd1) >= {1'b0, TIMEOUT});

endmodule

// File: rtl/tdes_seq.sv
// tdes_seq: Triple-DES pass sequencer driving an external DES engine.
// Runs one (single DES) or three (EDE) engine passes per request.
module tdes_seq
  import tdes_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  tdes_if.slave       bus,
  output logic        des_i_valid,
  output logic [63:0] des_data,
  output logic [63:0] des_key,
  output logic        des_decrypt,
  input  logic        des_o_valid,
  input  logic [63:0] des_result
);

  logic [2:0]  st;
  logic [2:0]  nxt;
  logic [1:0]  pass;
  logic [1:0]  last;
  req_t        req;
  logic [63:0] blk;
  logic [63:0] res;
  logic        dov_q;
  logic        accept;
  logic        done_evt;
  logic        is_last;
  logic        expired;
  logic        t_clear;
  logic        t_en;
  pass_cfg_t   cfg;

  assign accept   = (st == S_IDLE) && bus.i_valid;
  assign done_evt = (st == S_WAIT) && des_o_valid && !dov_q;
  assign last     = req.mode ? PASS_2 : PASS_0;
  assign is_last  = (pass == last);
  assign cfg      = sel_pass(pass, req);
  assign t_clear  = (st == S_ISSUE);
  assign t_en     = (st == S_WAIT);

  assign des_i_valid = (st == S_ISSUE);
  assign des_data    = blk;
  assign des_key     = cfg.key;
  assign des_decrypt = cfg.decrypt;

  assign bus.o_ready = (st == S_IDLE);
  assign bus.o_valid = (st == S_DONE);
  assign bus.o_error = (st == S_ERR);
  assign bus.o_data  = res;
  assign bus.o_pass  = pass;

  tdes_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (t_clear),
    .enable (t_en),
    .expired(expired)
  );

  // A completion on the expiry edge wins over the abort.
  always_comb begin
    nxt = st;
    unique case (1'b1)
      st == S_IDLE:  nxt = accept ? S_ISSUE : S_IDLE;
      st == S_ISSUE: nxt = S_WAIT;
      st == S_WAIT: begin
        if (done_evt) begin
          nxt = is_last ? S_DONE : S_ISSUE;
        end else if (expired) begin
          nxt = S_ERR;
        end
      end
      st == S_DONE:  nxt = S_IDLE;
      st == S_ERR:   nxt = S_IDLE;
      default:       nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= S_IDLE;
      pass  <= PASS_0;
      dov_q <= 1'b0;
      req   <= '0;
      blk   <= '0;
      res   <= '0;
    end else begin
      st    <= nxt;
      dov_q <= des_o_valid;
      if (accept) begin
        blk         <= bus.i_data;
        req.mode    <= bus.i_mode;
        req.decrypt <= bus.i_decrypt;
        req.key1    <= bus.i_key1;
        req.key2    <= bus.i_key2;
        req.key3    <= bus.i_key3;
        pass        <= PASS_0;
      end
      if (done_evt) begin
        blk <= des_result;
        if (is_last) begin
          res <= des_result;
        end else begin
          pass <= pass + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdes_seq.sv
// tb_tdes_seq: random and directed checks of tdes_seq against
// a pass-list reference model and an invertible toy engine stub.
module tb_tdes_seq;
  import tdes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdes_if bus ();

  logic        des_i_valid;
  logic [63:0] des_data;
  logic [63:0] des_key;
  logic        des_decrypt;
  logic        des_o_valid = 1'b0;
  logic [63:0] des_result = '0;

  tdes_seq #(
    .TIMEOUT(TIMEOUT_DEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .des_i_valid(des_i_valid),
    .des_data   (des_data),
    .des_key    (des_key),
    .des_decrypt(des_decrypt),
    .des_o_valid(des_o_valid),
    .des_result (des_result)
  );

  // Invertible stand-in for DES: rotl(d^k,13) / rotr(d,13)^k.
  function automatic logic [63:0] toy(
    input logic [63:0] d,
    input logic [63:0] k,
    input logic        dec
  );
    logic [63:0] x;
    if (!dec) begin
      x = d ^ k;
      return {x[50:0], x[63:51]};
    end
    return {d[12:0], d[63:13]} ^ k;
  endfunction

  int          stub_lat = 10;
  bit          stub_hang = 1'b0;
  int          scnt = 0;
  logic [63:0] sres = '0;

  always @(posedge clk) begin
    if (des_i_valid) begin
      des_o_valid <= 1'b0;
      scnt        <= stub_lat - 1;
      sres        <= toy(des_data, des_key, des_decrypt);
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
      if (scnt == 1 && !stub_hang) begin
        des_o_valid <= 1'b1;
        des_result  <= sres;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_acc = 0;
  int          n_di = 0;
  int          n_ov = 0;
  int          n_er = 0;
  int          acc_n = 0;
  int          di_n = 0;
  int          ov_n = 0;
  int          er_n = 0;
  logic [63:0] ov_data = '0;
  logic [63:0] key_q[$];
  logic        dir_q[$];
  logic [1:0]  pass_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.i_valid && bus.o_ready) begin
      n_acc = n_acc + 1;
      acc_n = cyc;
    end
    if (des_i_valid) begin
      n_di = n_di + 1;
      di_n = cyc;
      key_q.push_back(des_key);
      dir_q.push_back(des_decrypt);
      pass_q.push_back(bus.o_pass);
    end
    if (bus.o_valid) begin
      n_ov    = n_ov + 1;
      ov_n    = cyc;
      ov_data = bus.o_data;
    end
    if (bus.o_error) begin
      n_er = n_er + 1;
      er_n = cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.i_mode    = 1'($urandom);
    bus.i_decrypt = 1'($urandom);
    bus.i_data    = {$urandom, $urandom};
    bus.i_key1    = {$urandom, $urandom};
    bus.i_key2    = {$urandom, $urandom};
    bus.i_key3    = {$urandom, $urandom};
  endtask

  task automatic start(
    input logic        mode,
    input logic        dec,
    input logic [63:0] d,
    input logic [63:0] k1,
    input logic [63:0] k2,
    input logic [63:0] k3
  );
    bus.i_valid   = 1'b1;
    bus.i_mode    = mode;
    bus.i_decrypt = dec;
    bus.i_data    = d;
    bus.i_key1    = k1;
    bus.i_key2    = k2;
    bus.i_key3    = k3;
  endtask

  task automatic run_txn(
    input  logic        mode,
    input  logic        dec,
    input  logic [63:0] d,
    input  logic [63:0] k1,
    input  logic [63:0] k2,
    input  logic [63:0] k3,
    input  int          lat,
    input  bit          hang,
    input  bit          hold,
    output logic [63:0] got
  );
    logic [63:0] ek[$];
    logic        ed[$];
    logic [63:0] exp;
    int          b_acc, b_di, b_q, b_ov, b_er, np;
    bit          ok;
    if (!mode) begin
      ek.push_back(k1); ed.push_back(dec);
    end else if (!dec) begin
      ek.push_back(k1); ed.push_back(1'b0);
      ek.push_back(k2); ed.push_back(1'b1);
      ek.push_back(k3); ed.push_back(1'b0);
    end else begin
      ek.push_back(k3); ed.push_back(1'b1);
      ek.push_back(k2); ed.push_back(1'b0);
      ek.push_back(k1); ed.push_back(1'b1);
    end
    exp = d;
    foreach (ek[i]) exp = toy(exp, ek[i], ed[i]);
    np = ek.size();
    stub_lat  = lat;
    stub_hang = hang;
    b_acc = n_acc; b_di = n_di; b_q = key_q.size();
    b_ov  = n_ov;  b_er = n_er;
    start(mode, dec, d, k1, k2, k3);
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      tick();
      ok = (n_acc > b_acc);
    end
    chk("accept", 64'(ok), 64'd1);
    if (!hold) begin
      bus.i_valid = 1'b0;
      scramble();
    end
    ok = 1'b0;
    for (int w = 0; w < 400 && !ok; w++) begin
      tick();
      ok = (n_ov > b_ov) || (n_er > b_er);
    end
    chk("finish", 64'(ok), 64'd1);
    got = ov_data;
    if (hang) begin
      chk("err_cnt", 64'(n_er - b_er), 64'd1);
      chk("err_noov", 64'(n_ov - b_ov), 64'd0);
      chk("err_lat", 64'(er_n - di_n), 64'(int'(TIMEOUT_DEF) + 1));
      chk("err_rdy", 64'(bus.o_ready), 64'd1);
    end else begin
      chk("ov_cnt", 64'(n_ov - b_ov), 64'd1);
      chk("ov_noerr", 64'(n_er - b_er), 64'd0);
      chk("npass", 64'(n_di - b_di), 64'(np));
      for (int i = 0; i < np; i++) begin
        if (key_q.size() > b_q + i) begin
          chk("key", key_q[b_q + i], ek[i]);
          chk("dir", 64'(dir_q[b_q + i]), 64'(ed[i]));
          chk("pass", 64'(pass_q[b_q + i]), 64'(i));
        end
      end
      chk("lat", 64'(ov_n - (acc_n + 1)), 64'(np * (lat + 1)));
      chk("data", ov_data, exp);
      chk("data_hold", bus.o_data, exp);
      if (hold) begin
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
          tick();
          ok = (n_acc > b_acc + 1);
        end
        chk("reacc", 64'(ok), 64'd1);
        chk("reacc_cyc", 64'(acc_n), 64'(ov_n + 1));
        bus.i_valid = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 400 && !ok; w++) begin
          tick();
          ok = (n_ov > b_ov + 1);
        end
        chk("reacc_fin", 64'(ok), 64'd1);
        chk("reacc_data", ov_data, exp);
      end
    end
  endtask

  localparam logic [63:0] K1 = 64'h0133457799BBCDFF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] PT = 64'h0123456789ABCDEF;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ct;
    logic [63:0] rt;
    int          b_ov, b_er, b_di;
    bit          ok;
    bus.i_valid = 1'b0;
    scramble();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 64'(bus.o_ready), 64'd1);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_error", 64'(bus.o_error), 64'd0);
    chk("rst_issue", 64'(des_i_valid), 64'd0);
    chk("rst_data", bus.o_data, 64'd0);
    chk("rst_pass", 64'(bus.o_pass), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_ready", 64'(bus.o_ready), 64'd1);

    run_txn(1'b1, 1'b0, PT, K1, K2, K1, 10, 1'b0, 1'b0, ct);
    run_txn(1'b1, 1'b1, ct, K1, K2, K1, 10, 1'b0, 1'b0, rt);
    chk("roundtrip", rt, PT);
    run_txn(1'b0, 1'b0, PT, K1, K2, K1, 66, 1'b0, 1'b0, ct);
    run_txn(1'b1, 1'b0, PT, K1, K2, K1, 10, 1'b1, 1'b0, ct);
    chk("err_odata", bus.o_data, toy(PT, K1, 1'b0));
    run_txn(1'b0, 1'b1, PT, K2, K1, K2, 127, 1'b0, 1'b0, ct);
    run_txn(1'b1, 1'b0, PT, K1, K2, K1, 10, 1'b0, 1'b1, ct);

    stub_lat  = 10;
    stub_hang = 1'b0;
    b_ov = n_ov; b_er = n_er; b_di = n_di;
    start(1'b1, 1'b0, PT, K1, K2, K1);
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      tick();
      ok = (n_di - b_di >= 2);
    end
    chk("rst_reach_p1", 64'(ok), 64'd1);
    bus.i_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_ready", 64'(bus.o_ready), 64'd1);
    chk("mid_issue", 64'(des_i_valid), 64'd0);
    chk("mid_pass", 64'(bus.o_pass), 64'd0);
    b_di = n_di;
    repeat (40) tick();
    chk("mid_noov", 64'(n_ov - b_ov), 64'd0);
    chk("mid_noerr", 64'(n_er - b_er), 64'd0);
    chk("mid_noissue", 64'(n_di - b_di), 64'd0);

    for (int t = 0; t < 25; t++) begin
      run_txn(1'($urandom), 1'($urandom), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, int'($urandom_range(20, 2)),
              1'b0, 1'b0, ct);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tdes_seq.md
TDES_SEQ -- requirements
Module: tdes_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd127: max cycles in WAIT per pass before abort.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 i_valid  in  1  request; accepted on any edge where i_valid && o_ready.
REQ-005 i_mode  in  1  0 = single DES (K1 only); 1 = Triple-DES EDE.
REQ-006 i_decrypt  in  1  0 = encrypt, 1 = decrypt.
REQ-007 i_data  in  64  input block.
REQ-008 i_key1 / i_key2 / i_key3  in  64 each  keys K1, K2, K3.
REQ-009 o_ready  out  1  high only in IDLE.
REQ-010 des_i_valid  out  1  one-cycle start pulse to the DES engine.
REQ-011 des_data  out  64  engine input block; equals the internal block register.
REQ-012 des_key  out  64  engine key for the current pass.
REQ-013 des_decrypt  out  1  engine direction for the current pass.
REQ-014 des_o_valid  in  1  engine done; level, held high until the next start.
REQ-015 des_result  in  64  engine output; sampled on completion.
REQ-016 o_valid  out  1  one-cycle result pulse.
REQ-017 o_data  out  64  result; stable from o_valid until the next acceptance.
REQ-018 o_error  out  1  one-cycle pulse on watchdog abort.
REQ-019 o_pass  out  2  current pass index 0..2, for debug.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, ERR; any illegal encoding SHALL go to IDLE.
REQ-021 On acceptance: capture i_data, the three keys, i_mode and i_decrypt; set pass=0; go to ISSUE.
REQ-022 ISSUE lasts exactly 1 cycle with des_i_valid=1, then goes to WAIT; des_i_valid SHALL be 0 in all other states.
REQ-023 Completion = des_o_valid && !des_o_valid_q, where des_o_valid_q is registered; completions outside WAIT SHALL be ignored.
REQ-024 On completion in WAIT: load des_result into the block register; if pass == last, go to DONE, else pass+1 and go to ISSUE.
REQ-025 last = 0 when mode=0; last = 2 when mode=1.
REQ-026 Encrypt EDE passes: (K1,enc), (K2,dec), (K3,enc).
REQ-027 Decrypt EDE passes: (K3,dec), (K2,enc), (K1,dec).
REQ-028 Single DES: one pass, (K1, i_decrypt).
REQ-029 DONE lasts 1 cycle: o_valid=1, o_data=block register; next state IDLE.
REQ-030 Watchdog: 8-bit counter, cleared in ISSUE, incremented each WAIT cycle; on reaching TIMEOUT with no completion, go to ERR.
REQ-031 ERR lasts 1 cycle: o_error=1, o_valid=0, o_data unchanged; next state IDLE.
REQ-032 Latency: with engine latency L (edges from des_i_valid sampled to des_o_valid sampled high), o_valid SHALL be high exactly P*(L+1) cycles after the acceptance edge, where P = number of passes.
REQ-033 i_valid while o_ready=0 SHALL be ignored; no queuing.
REQ-034 A completion on the same edge the watchdog reaches TIMEOUT SHALL take priority over the abort.

Reset
REQ-035 While rst_n=0 at an edge: state=IDLE, pass=0, watchdog=0, des_o_valid_q=0.
REQ-036 Reset values: o_valid=0, o_error=0, des_i_valid=0, o_data=0, o_pass=0; o_ready=1 from the first cycle after reset.
REQ-037 Reset mid-operation SHALL abort without an o_valid or o_error pulse.

Structure
REQ-038 Package tdes_pkg SHALL hold the state encoding, pass constants (PASS_0..PASS_2) and the TIMEOUT default.
REQ-039 Watchdog SHALL be sub-module tdes_timer (inputs clear, enable; output expired).
REQ-040 Key/direction selection SHALL be combinational from (pass, mode, decrypt) and registered keys.

Verification
REQ-041 Engine stub with L=10, mode=1, enc, keys 0133457799BBCDFF / 0E329232EA6D0D73 / 0133457799BBCDFF, data 0123456789ABCDEF -> des_key sequence K1,K2,K3; des_decrypt 0,1,0; o_valid at acceptance+33; o_data = golden 3DES result.
REQ-042 Same as REQ-041 with mode=1, dec -> keys K3,K2,K1; des_decrypt 1,0,1; output equals the REQ-041 plaintext.
REQ-043 mode=0, enc, L=66 -> exactly one des_i_valid pulse; o_valid at acceptance+67.
REQ-044 Stub never completes, TIMEOUT=127 -> o_error pulse 128 cycles after des_i_valid; o_valid stays 0; o_ready=1 on the next cycle.
REQ-045 i_valid held high throughout the REQ-041 run -> second acceptance only on the cycle after the o_valid pulse.
REQ-046 rst_n low for 1 cycle during pass 1 -> IDLE, o_ready=1 next cycle, no o_valid or o_error pulse, des_i_valid=0.
